// File: rtl/mc_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mc_ctrl_pkg
// Purpose  : Shared encodings for the multicycle RV32I main control FSM and
//            the downstream ALU control decoder.
// Revision : 1.0 - initial release
// ============================================================================
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_RESET    = 4'b0000,
    ST_IF       = 4'b0001,
    ST_ID       = 4'b0010,
    ST_JMP_EX   = 4'b0011,
    ST_EX_I     = 4'b0101,
    ST_MEM      = 4'b0110,
    ST_EX_R     = 4'b0111,
    ST_UPPER_EX = 4'b1000,
    ST_BR_EX    = 4'b1001,
    ST_WB       = 4'b1010,
    ST_PC_INC   = 4'b1011,
    ST_HALTED   = 4'b1100
  } state_t;

  localparam logic [6:0] c_OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] c_OPC_STORE  = 7'b0100011;
  localparam logic [6:0] c_OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] c_OPC_OP     = 7'b0110011;
  localparam logic [6:0] c_OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] c_OPC_JAL    = 7'b1101111;
  localparam logic [6:0] c_OPC_JALR   = 7'b1100111;
  localparam logic [6:0] c_OPC_LUI    = 7'b0110111;
  localparam logic [6:0] c_OPC_AUIPC  = 7'b0010111;

  // Bit positions in the one-hot opcode class vector
  localparam int c_CLS_LOAD   = 0;
  localparam int c_CLS_STORE  = 1;
  localparam int c_CLS_OPIMM  = 2;
  localparam int c_CLS_OP     = 3;
  localparam int c_CLS_BRANCH = 4;
  localparam int c_CLS_JAL    = 5;
  localparam int c_CLS_JALR   = 6;
  localparam int c_CLS_LUI    = 7;
  localparam int c_CLS_AUIPC  = 8;
  localparam int c_CLS_W      = 9;

  localparam logic [1:0] c_PCSRC_PC4  = 2'b00;
  localparam logic [1:0] c_PCSRC_ALU  = 2'b01;
  localparam logic [1:0] c_PCSRC_JALR = 2'b10;

  localparam logic [1:0] c_WBSEL_ALU = 2'b00;
  localparam logic [1:0] c_WBSEL_MEM = 2'b01;
  localparam logic [1:0] c_WBSEL_PC4 = 2'b10;

  // jalr x0, 0(x1): the core treats a plain "ret" as the halt instruction
  localparam logic [31:0] c_HALT_INST = 32'h00008067;

endpackage
`default_nettype wire

// File: rtl/opcode_class_decode.sv
`default_nettype none
// ============================================================================
// Module   : opcode_class_decode
// Purpose  : Combinational opcode -> one-hot instruction class decode.
// Revision : 1.0 - initial release
// ============================================================================
module opcode_class_decode
  import mc_ctrl_pkg::*;
(
  input  logic [6:0]         i_opcode,
  output logic [c_CLS_W-1:0] o_class
);

  always_comb begin
    o_class               = '0;
    o_class[c_CLS_LOAD]   = (i_opcode == c_OPC_LOAD);
    o_class[c_CLS_STORE]  = (i_opcode == c_OPC_STORE);
    o_class[c_CLS_OPIMM]  = (i_opcode == c_OPC_OPIMM);
    o_class[c_CLS_OP]     = (i_opcode == c_OPC_OP);
    o_class[c_CLS_BRANCH] = (i_opcode == c_OPC_BRANCH);
    o_class[c_CLS_JAL]    = (i_opcode == c_OPC_JAL);
    o_class[c_CLS_JALR]   = (i_opcode == c_OPC_JALR);
    o_class[c_CLS_LUI]    = (i_opcode == c_OPC_LUI);
    o_class[c_CLS_AUIPC]  = (i_opcode == c_OPC_AUIPC);
  end

endmodule
`default_nettype wire

// File: rtl/mc_main_control.sv
`default_nettype none
// ============================================================================
// Module   : mc_main_control
// Purpose  : Multicycle RV32I main control FSM: state sequencing, datapath
//            strobes, ALU control bundle, halt detection, retire counter.
// Revision : 1.0 - initial release
// ============================================================================
module mc_main_control
  import mc_ctrl_pkg::*;
(
  input  logic        CLK,
  input  logic        RSTn,
  input  logic [31:0] INST,
  input  logic        BR_TAKEN,
  output logic [10:0] ALU_CONTROL,
  output logic        PC_WRITE,
  output logic [1:0]  PC_SRC,
  output logic        IR_WRITE,
  output logic        I_MEM_CSN,
  output logic        D_MEM_CSN,
  output logic        D_MEM_WEN,
  output logic        RF_WE,
  output logic [1:0]  WB_SEL,
  output logic        HALT,
  output logic [31:0] NUM_INST
);

  state_t             r_state;
  state_t             w_next_state;
  logic [c_CLS_W-1:0] w_cls;
  logic [31:0]        r_num_inst;
  logic               w_retire;

  opcode_class_decode u_opcode_class_decode (
    .i_opcode (INST[6:0]),
    .o_class  (w_cls)
  );

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) r_state <= ST_RESET;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_RESET: w_next_state = ST_IF;
      ST_IF:    w_next_state = ST_ID;
      ST_ID: begin
        // Halt is matched on the full word before the JALR class applies
        if (INST == c_HALT_INST)
          w_next_state = ST_HALTED;
        else if (w_cls[c_CLS_JAL] || w_cls[c_CLS_JALR])
          w_next_state = ST_JMP_EX;
        else if (w_cls[c_CLS_LOAD] || w_cls[c_CLS_STORE] || w_cls[c_CLS_OPIMM])
          w_next_state = ST_EX_I;
        else if (w_cls[c_CLS_OP])
          w_next_state = ST_EX_R;
        else if (w_cls[c_CLS_LUI] || w_cls[c_CLS_AUIPC])
          w_next_state = ST_UPPER_EX;
        else if (w_cls[c_CLS_BRANCH])
          w_next_state = ST_BR_EX;
        else
          w_next_state = ST_PC_INC;
      end
      ST_JMP_EX:   w_next_state = ST_WB;
      ST_EX_I:     w_next_state = (w_cls[c_CLS_LOAD] || w_cls[c_CLS_STORE]) ? ST_MEM : ST_WB;
      ST_MEM:      w_next_state = w_cls[c_CLS_STORE] ? ST_PC_INC : ST_WB;
      ST_EX_R:     w_next_state = ST_WB;
      ST_UPPER_EX: w_next_state = ST_WB;
      ST_BR_EX:    w_next_state = BR_TAKEN ? ST_IF : ST_PC_INC;
      ST_WB:       w_next_state = ST_IF;
      ST_PC_INC:   w_next_state = ST_IF;
      ST_HALTED:   w_next_state = ST_HALTED;
      default:     w_next_state = ST_RESET;
    endcase
  end

  always_comb begin
    ALU_CONTROL = (r_state == ST_RESET) ? 11'd0 : {INST[6:0], r_state};
    PC_WRITE    = 1'b0;
    PC_SRC      = c_PCSRC_PC4;
    IR_WRITE    = 1'b0;
    I_MEM_CSN   = 1'b1;
    D_MEM_CSN   = 1'b1;
    D_MEM_WEN   = 1'b1;
    RF_WE       = 1'b0;
    WB_SEL      = c_WBSEL_ALU;
    HALT        = 1'b0;
    case (r_state)
      ST_IF: begin
        I_MEM_CSN = 1'b0;
        IR_WRITE  = 1'b1;
      end
      ST_MEM: begin
        D_MEM_CSN = 1'b0;
        D_MEM_WEN = ~w_cls[c_CLS_STORE];
      end
      ST_BR_EX: begin
        if (BR_TAKEN) begin
          PC_WRITE = 1'b1;
          PC_SRC   = c_PCSRC_ALU;
        end
      end
      ST_WB: begin
        RF_WE    = 1'b1;
        PC_WRITE = 1'b1;
        if (w_cls[c_CLS_JAL])       PC_SRC = c_PCSRC_ALU;
        else if (w_cls[c_CLS_JALR]) PC_SRC = c_PCSRC_JALR;
        if (w_cls[c_CLS_JAL] || w_cls[c_CLS_JALR]) WB_SEL = c_WBSEL_PC4;
        else if (w_cls[c_CLS_LOAD])                WB_SEL = c_WBSEL_MEM;
      end
      ST_PC_INC: PC_WRITE = 1'b1;
      ST_HALTED: HALT     = 1'b1;
      default: ;
    endcase
  end

  // Only completions of a real instruction count; RESET->IF does not
  assign w_retire = (w_next_state == ST_IF) &&
                    ((r_state == ST_WB) || (r_state == ST_PC_INC) || (r_state == ST_BR_EX));

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn)         r_num_inst <= 32'd0;
    else if (w_retire) r_num_inst <= r_num_inst + 32'd1;
  end

  assign NUM_INST = r_num_inst;

endmodule
`default_nettype wire

// File: tb/tb_mc_main_control.sv
`default_nettype none
// ============================================================================
// Module   : tb_mc_main_control
// Purpose  : Self-checking bench for mc_main_control (directed table plus
//            random instruction stream against a per-instruction path model).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mc_main_control;

  localparam logic [3:0] S_RESET = 4'b0000, S_IF = 4'b0001, S_ID = 4'b0010,
                         S_JMP_EX = 4'b0011, S_EX_I = 4'b0101, S_MEM = 4'b0110,
                         S_EX_R = 4'b0111, S_UPPER_EX = 4'b1000, S_BR_EX = 4'b1001,
                         S_WB = 4'b1010, S_PC_INC = 4'b1011, S_HALTED = 4'b1100;

  localparam logic [6:0] OP_LOAD = 7'b0000011, OP_STORE = 7'b0100011,
                         OP_OPIMM = 7'b0010011, OP_OP = 7'b0110011,
                         OP_BRANCH = 7'b1100011, OP_JAL = 7'b1101111,
                         OP_JALR = 7'b1100111, OP_LUI = 7'b0110111,
                         OP_AUIPC = 7'b0010111;

  localparam logic [31:0] HALT_WORD = 32'h00008067;

  logic        CLK = 1'b0;
  logic        RSTn;
  logic [31:0] INST;
  logic        BR_TAKEN;
  logic [10:0] ALU_CONTROL;
  logic        PC_WRITE, IR_WRITE, I_MEM_CSN, D_MEM_CSN, D_MEM_WEN, RF_WE, HALT;
  logic [1:0]  PC_SRC, WB_SEL;
  logic [31:0] NUM_INST;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] model_num = 32'd0;

  mc_main_control dut (
    .CLK         (CLK),
    .RSTn        (RSTn),
    .INST        (INST),
    .BR_TAKEN    (BR_TAKEN),
    .ALU_CONTROL (ALU_CONTROL),
    .PC_WRITE    (PC_WRITE),
    .PC_SRC      (PC_SRC),
    .IR_WRITE    (IR_WRITE),
    .I_MEM_CSN   (I_MEM_CSN),
    .D_MEM_CSN   (D_MEM_CSN),
    .D_MEM_WEN   (D_MEM_WEN),
    .RF_WE       (RF_WE),
    .WB_SEL      (WB_SEL),
    .HALT        (HALT),
    .NUM_INST    (NUM_INST)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string       name;
    logic [31:0] inst;
    logic        br;
    int          cycles;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Expected outputs in a given state, from the strobe rules of the design
  task automatic check_state(input logic [3:0] s, input logic [31:0] inst, input logic br);
    logic [6:0]  op;
    logic [1:0]  e_pcsrc, e_wbsel;
    logic        e_pcw, jmp;
    op      = inst[6:0];
    jmp     = (op == OP_JAL) || (op == OP_JALR);
    e_pcw   = (s == S_WB) || (s == S_PC_INC) || ((s == S_BR_EX) && br);
    e_pcsrc = 2'b00;
    if (s == S_WB && op == OP_JAL)       e_pcsrc = 2'b01;
    else if (s == S_WB && op == OP_JALR) e_pcsrc = 2'b10;
    else if (s == S_BR_EX && br)         e_pcsrc = 2'b01;
    e_wbsel = 2'b00;
    if (s == S_WB && jmp)                e_wbsel = 2'b10;
    else if (s == S_WB && op == OP_LOAD) e_wbsel = 2'b01;
    chk("alu_control", 32'(ALU_CONTROL), (s == S_RESET) ? 32'd0 : 32'({op, s}));
    chk("pc_write",  32'(PC_WRITE),  32'(e_pcw));
    chk("pc_src",    32'(PC_SRC),    32'(e_pcsrc));
    chk("ir_write",  32'(IR_WRITE),  32'(s == S_IF));
    chk("i_mem_csn", 32'(I_MEM_CSN), 32'(s != S_IF));
    chk("d_mem_csn", 32'(D_MEM_CSN), 32'(s != S_MEM));
    chk("d_mem_wen", 32'(D_MEM_WEN), 32'(!(s == S_MEM && op == OP_STORE)));
    chk("rf_we",     32'(RF_WE),     32'(s == S_WB));
    chk("wb_sel",    32'(WB_SEL),    32'(e_wbsel));
    chk("halt",      32'(HALT),      32'(s == S_HALTED));
    chk("num_inst",  NUM_INST,       model_num);
  endtask

  function automatic bit known_op(input logic [6:0] op);
    return op inside {OP_LOAD, OP_STORE, OP_OPIMM, OP_OP, OP_BRANCH,
                      OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};
  endfunction

  // Starting at a negedge in IF: issue one instruction and follow it to the next IF
  task automatic run_inst(input logic [31:0] inst, input logic br, input int exp_cyc);
    logic [3:0] path[$];
    logic [3:0] exp_s;
    logic [6:0] op;
    int         k;
    op = inst[6:0];
    path = {S_IF, S_ID};
    case (op)
      OP_JAL, OP_JALR:  path = {path, S_JMP_EX, S_WB};
      OP_LOAD:          path = {path, S_EX_I, S_MEM, S_WB};
      OP_STORE:         path = {path, S_EX_I, S_MEM, S_PC_INC};
      OP_OPIMM:         path = {path, S_EX_I, S_WB};
      OP_OP:            path = {path, S_EX_R, S_WB};
      OP_LUI, OP_AUIPC: path = {path, S_UPPER_EX, S_WB};
      OP_BRANCH:        path = br ? {path, S_BR_EX} : {path, S_BR_EX, S_PC_INC};
      default:          path = {path, S_PC_INC};
    endcase
    k = 0;
    for (int guard = 0; guard < 20; guard++) begin
      if (k == 0) INST = inst;
      exp_s    = (k < path.size()) ? path[k] : 4'hF;
      BR_TAKEN = (exp_s == S_BR_EX) ? br : 1'($urandom);
      #1;
      check_state(exp_s, inst, br);
      @(posedge CLK);
      @(negedge CLK);
      k++;
      if (ALU_CONTROL[3:0] == S_IF) break;
    end
    model_num = model_num + 32'd1;
    chk("cycles", 32'(k), 32'(exp_cyc));
    chk("retired", NUM_INST, model_num);
  endtask

  task automatic step_check(input logic [3:0] s, input logic [31:0] inst);
    @(posedge CLK);
    @(negedge CLK);
    BR_TAKEN = 1'($urandom);
    #1;
    check_state(s, inst, 1'b0);
  endtask

  task automatic do_reset();
    RSTn = 1'b0;
    repeat (2) @(negedge CLK);
    model_num = 32'd0;
    INST = $urandom;
    #1;
    check_state(S_RESET, INST, 1'b0);
    @(negedge CLK);
    RSTn = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
  endtask

  vec_t vecs[11];
  logic [6:0] ops[9];

  initial begin
    logic [31:0] inst;
    logic [6:0]  op;
    logic        br;
    int          ncyc;

    vecs[0]  = '{"add",        32'h003100B3, 1'b0, 4};
    vecs[1]  = '{"lw",         32'h0000A083, 1'b0, 5};
    vecs[2]  = '{"sw",         32'h0020A023, 1'b0, 5};
    vecs[3]  = '{"beq_taken",  32'h00208463, 1'b1, 3};
    vecs[4]  = '{"beq_not",    32'h00208463, 1'b0, 4};
    vecs[5]  = '{"jal",        32'h008000EF, 1'b0, 4};
    vecs[6]  = '{"lui",        32'h000010B7, 1'b0, 4};
    vecs[7]  = '{"auipc",      32'h00001097, 1'b0, 4};
    vecs[8]  = '{"addi",       32'h00108093, 1'b0, 4};
    vecs[9]  = '{"unknown",    32'h0000007F, 1'b0, 3};
    vecs[10] = '{"jalr",       32'h000080E7, 1'b0, 4};
    ops = '{OP_LOAD, OP_STORE, OP_OPIMM, OP_OP, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};

    RSTn = 1'b0;
    INST = 32'd0;
    BR_TAKEN = 1'b0;
    do_reset();

    foreach (vecs[i]) run_inst(vecs[i].inst, vecs[i].br, vecs[i].cycles);

    for (int n = 0; n < 300; n++) begin
      op = ops[$urandom_range(0, 8)];
      if ($urandom_range(0, 9) == 0) begin
        op = 7'($urandom);
        while (known_op(op)) op = 7'($urandom);
      end
      inst = {25'($urandom), op};
      if (inst == HALT_WORD) inst[31] = 1'b1;
      br = 1'($urandom);
      case (op)
        OP_LOAD, OP_STORE: ncyc = 5;
        OP_BRANCH:         ncyc = br ? 3 : 4;
        default:           ncyc = known_op(op) ? 4 : 3;
      endcase
      run_inst(inst, br, ncyc);
    end

    // Counter wrap from all-ones
    force dut.r_num_inst = 32'hFFFFFFFF;
    #1;
    release dut.r_num_inst;
    model_num = 32'hFFFFFFFF;
    run_inst(32'h003100B3, 1'b0, 4);
    chk("num_wrap", NUM_INST, 32'd0);

    // Asynchronous reset in MEM of a store
    INST = 32'h0020A023;
    #1;
    check_state(S_IF, INST, 1'b0);
    step_check(S_ID, INST);
    step_check(S_EX_I, INST);
    step_check(S_MEM, INST);
    #2;
    RSTn = 1'b0;
    #1;
    model_num = 32'd0;
    check_state(S_RESET, INST, 1'b0);
    @(negedge CLK);
    RSTn = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    run_inst(32'h0000A083, 1'b0, 5);

    // jalr then halt: sticky, not counted
    run_inst(32'h000080E7, 1'b0, 4);
    INST = HALT_WORD;
    #1;
    check_state(S_IF, INST, 1'b0);
    step_check(S_ID, INST);
    for (int c = 0; c < 100; c++) step_check(S_HALTED, INST);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
